dual_port_blockram_arbiter: RTL

- Shares one dual_port_blockram (one read port, one write port) between two requesters, each issuing read or write requests over valid/ready handshakes.
- Per cycle it issues at most one read and at most one write to the RAM. Same-type conflicts are resolved round-robin.
- Read data returns to the issuing requester with fixed latency.
- Same-cycle read/write to one address is resolved by forwarding, so the reader sees the new data.
- Sits between cache/tag logic and the blockram.

---
 rtl/dual_port_blockram_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dual_port_blockram_arbiter.sv
// Arbiter sharing one single-read/single-write blockram between two requesters.
// Round-robin resolution within a class, fixed one-cycle read latency, write-to-read forwarding.
module dual_port_blockram_arbiter #(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int NUMBER_SET                  = 64,
    parameter int SET_PTR_WIDTH_IN_BITS       = 6
) (
    input  logic                                     clk_in,
    input  logic                                     reset_in,
    input  logic [1:0]                               req_valid_in,
    input  logic [1:0]                               req_write_in,
    input  logic [2*SET_PTR_WIDTH_IN_BITS-1:0]       req_addr_in,
    input  logic [2*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req_data_in,
    output logic [1:0]                               req_ready_out,
    output logic [1:0]                               resp_valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   resp_data_out,
    output logic                                     ram_read_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]         ram_read_set_addr_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   ram_read_element_in,
    output logic                                     ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]         ram_write_set_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   ram_write_element_out
);

    localparam int DW = SINGLE_ELEMENT_SIZE_IN_BITS;
    localparam int AW = SET_PTR_WIDTH_IN_BITS;

    // Depth must match the address width since addresses are never range-checked.
    if (NUMBER_SET != (1 << AW)) begin : g_depth_mismatch
        $error("NUMBER_SET must equal 2**SET_PTR_WIDTH_IN_BITS");
    end

    logic          rr_ptr_r;
    logic          resp_pending_r;
    logic          resp_id_r;
    logic          fwd_hit_r;
    logic [DW-1:0] fwd_data_r;

    logic [1:0]    read_req_s;
    logic [1:0]    write_req_s;
    logic          read_conflict_s;
    logic          write_conflict_s;
    logic          read_winner_s;
    logic          write_winner_s;
    logic          read_grant_s;
    logic          write_grant_s;
    logic [AW-1:0] read_addr_s;
    logic [AW-1:0] write_addr_s;
    logic [DW-1:0] write_data_s;

    // Classify requests and pick one winner per class; reset masks every request.
    always_comb begin
        read_req_s       = 2'b00;
        write_req_s      = 2'b00;
        if (reset_in) begin
            read_req_s  = req_valid_in & ~req_write_in;
            write_req_s = req_valid_in & req_write_in;
        end else begin
            read_req_s  = 2'b00;
            write_req_s = 2'b00;
        end
        read_conflict_s  = &read_req_s;
        write_conflict_s = &write_req_s;
        read_grant_s     = |read_req_s;
        write_grant_s    = |write_req_s;
        read_winner_s    = read_conflict_s  ? rr_ptr_r : read_req_s[1];
        write_winner_s   = write_conflict_s ? rr_ptr_r : write_req_s[1];
        read_addr_s      = read_winner_s  ? req_addr_in[2*AW-1:AW] : req_addr_in[AW-1:0];
        write_addr_s     = write_winner_s ? req_addr_in[2*AW-1:AW] : req_addr_in[AW-1:0];
        write_data_s     = write_winner_s ? req_data_in[2*DW-1:DW] : req_data_in[DW-1:0];
    end

    // Grant vector and RAM drive; idle address/data lines are held at zero.
    always_comb begin
        req_ready_out          = 2'b00;
        ram_read_en_out        = read_grant_s;
        ram_write_en_out       = write_grant_s;
        ram_read_set_addr_out  = {AW{1'b0}};
        ram_write_set_addr_out = {AW{1'b0}};
        ram_write_element_out  = {DW{1'b0}};
        if (read_grant_s) begin
            req_ready_out[read_winner_s] = 1'b1;
            ram_read_set_addr_out        = read_addr_s;
        end else begin
            ram_read_set_addr_out = {AW{1'b0}};
        end
        if (write_grant_s) begin
            req_ready_out[write_winner_s] = 1'b1;
            ram_write_set_addr_out        = write_addr_s;
            ram_write_element_out         = write_data_s;
        end else begin
            ram_write_set_addr_out = {AW{1'b0}};
            ram_write_element_out  = {DW{1'b0}};
        end
    end

    // Round-robin pointer and one-stage response tracking.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            rr_ptr_r       <= 1'b0;
            resp_pending_r <= 1'b0;
            resp_id_r      <= 1'b0;
            fwd_hit_r      <= 1'b0;
            fwd_data_r     <= {DW{1'b0}};
        end else begin
            if (read_conflict_s) begin
                rr_ptr_r <= ~read_winner_s;
            end else if (write_conflict_s) begin
                rr_ptr_r <= ~write_winner_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            resp_pending_r <= read_grant_s;
            if (read_grant_s) begin
                resp_id_r  <= read_winner_s;
                fwd_hit_r  <= write_grant_s && (write_addr_s == read_addr_s);
                fwd_data_r <= write_data_s;
            end else begin
                fwd_hit_r <= 1'b0;
            end
        end
    end

    // The RAM returns pre-write data on a same-address collision, so forwarded data takes priority.
    always_comb begin
        resp_valid_out = 2'b00;
        resp_data_out  = {DW{1'b0}};
        if (resp_pending_r && reset_in) begin
            resp_valid_out[resp_id_r] = 1'b1;
            resp_data_out             = fwd_hit_r ? fwd_data_r : ram_read_element_in;
        end else begin
            resp_valid_out = 2'b00;
            resp_data_out  = {DW{1'b0}};
        end
    end

endmodule
